seq_ctrl_ws: RTL and testbench
==============================

SEQ_CTRL_WS -- requirements
Module: seq_ctrl_ws

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: the number of consecutive no-ack cycles in a memory wait state before a bus error; 0 disables the timeout.
REQ-002 SHALL have parameter TO_W, default 4: wait-counter width; legal only if TIMEOUT < 2**TO_W.
REQ-003 SHALL have parameter IC_W, default 16: retired-instruction counter width.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port opcode, input, 3 bits: instruction opcode from the IR data path.
REQ-007 SHALL have port zero, input, 1 bit: accumulator-is-zero flag.
REQ-008 SHALL have port mem_ack, input, 1 bit: memory completes the current read or write this cycle.
REQ-009 SHALL have port resume, input, 1 bit: leave the HALT state.
REQ-010 SHALL have port step_en, input, 1 bit: single-step mode enable.
REQ-011 SHALL have port step, input, 1 bit: single-step advance pulse.
REQ-012 SHALL have outputs mem_rd, mem_wr, load_ir, inc_pc, load_ac, load_pc, halt and err, each 1 bit: data-path and memory controls.
REQ-013 SHALL have output state_o, 4 bits: current state encoding.
REQ-014 SHALL have output instr_cnt, IC_W bits: retired-instruction count.

Function
REQ-015 SHALL decode opcodes as 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP; ALU class = 010..101.
REQ-016 SHALL implement states, encoded as follows: ADDR=0, IFETCH=1, ILOAD=2, DECODE=3, OPFETCH=4, EXEC=5, STORE=6, HALT=7, ERR=8.
REQ-017 ADDR SHALL assert no outputs and go to IFETCH, except that it SHALL stay in ADDR while step_en=1 and step=0.
REQ-018 IFETCH SHALL assert mem_rd and go to ILOAD on mem_ack=1; otherwise it SHALL stay in IFETCH.
REQ-019 ILOAD SHALL assert mem_rd and load_ir, capture opcode into opcode_q, and go to DECODE.
REQ-020 DECODE SHALL assert inc_pc and branch on opcode_q: HLT to HALT, ALU class to OPFETCH, SKZ or JMP to EXEC, STO to STORE.
REQ-021 OPFETCH SHALL assert mem_rd and go to EXEC on mem_ack=1; otherwise it SHALL stay in OPFETCH.
REQ-022 EXEC SHALL assert outputs according to opcode_q (ALU class: mem_rd and load_ac; SKZ: inc_pc = zero sampled this cycle; JMP: load_pc) and then go to ADDR.
REQ-023 STORE SHALL assert mem_wr and go to ADDR on mem_ack=1; otherwise it SHALL stay in STORE.
REQ-024 HALT SHALL assert halt and stay in HALT until resume=1, then go to ADDR.
REQ-025 ERR SHALL assert err and halt and be sticky until reset; resume SHALL be ignored in ERR.
REQ-026 Wait counter: cleared on entry to IFETCH, OPFETCH or STORE, and incremented on each wait-state cycle with mem_ack=0.
REQ-027 When TIMEOUT>0, the TIMEOUT-th consecutive no-ack cycle SHALL move to ERR, and an ack arriving on that same cycle SHALL take priority.
REQ-028 mem_ack outside IFETCH, OPFETCH and STORE SHALL be ignored.
REQ-029 All outputs SHALL be decoded combinationally from state, opcode_q and zero, and SHALL be glitch-free per registered state.
REQ-030 instr_cnt SHALL increment by 1 on each transition EXEC→ADDR, STORE→ADDR and DECODE→HALT, and SHALL wrap modulo 2**IC_W.
REQ-031 Zero-wait latency SHALL be: ALU class 6 cycles ADDR→ADDR; SKZ, JMP and STO 5 cycles; HLT 4 cycles to HALT.
REQ-032 Each wait cycle with no ack SHALL add exactly 1 cycle to the latency.
REQ-033 resume and step in the same cycle in HALT SHALL move to ADDR, after which REQ-017 applies.
REQ-034 step outside ADDR SHALL be ignored.
REQ-035 At most one of mem_rd and mem_wr SHALL be asserted in any cycle.

Reset
REQ-036 rst=0 SHALL immediately force state ADDR and clear opcode_q, the wait counter and instr_cnt, regardless of clk.
REQ-037 During and immediately after reset all control outputs SHALL be 0 and state_o SHALL be 0.
REQ-038 Reset asserted in any state, including a wait state or ERR, SHALL abort the operation with no partial outputs after the asynchronous edge.
REQ-039 After rst rises, the first rising clk edge SHALL evaluate ADDR transitions.

Verification
REQ-040 Zero-wait ADD: opcode=010 with mem_ack held at 1 -> states 0,1,2,3,4,5,0; load_ac asserted only in state 5; instr_cnt 0→1.
REQ-041 SKZ with zero=1 then with zero=0: inc_pc SHALL be asserted in EXEC for the first and not for the second; each instruction takes 5 cycles.
REQ-042 STO with mem_ack delayed 3 cycles: mem_wr SHALL be asserted 4 cycles in STORE and mem_rd never asserted concurrently; the instruction takes 8 cycles total.
REQ-043 Timeout with TIMEOUT=8 and mem_ack=0 in IFETCH: state 8 SHALL be reached after 8 IFETCH cycles, err=1 and halt=1; resume=1 SHALL then have no effect.
REQ-044 HLT then resume: state 7 SHALL hold halt=1 while resume=0, and resume=1 SHALL move to ADDR on the next edge; single-step with step_en=1 SHALL hold state 0 until a step pulse and execute exactly one instruction per pulse.
REQ-045 Wrap and reset: with IC_W=2, 5 JMPs SHALL give instr_cnt=1; rst=0 mid-OPFETCH SHALL give state_o=0, all outputs 0 and instr_cnt=0 asynchronously.

Source files
------------

// File: rtl/seq_ctrl_ws.sv
// seq_ctrl_ws: multi-cycle sequencer for an 8-opcode accumulator CPU with
// memory wait states, bus-error timeout, halt/resume and single-step.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   opcode     instruction opcode from the IR data path (captured in ILOAD)
//   zero       accumulator-is-zero flag (used by SKZ in EXEC)
//   mem_ack    memory completes the current read/write (wait states only)
//   resume     leave HALT
//   step_en    single-step mode: hold in ADDR until a step pulse
//   step       single-step advance pulse
//   mem_rd, mem_wr, load_ir, inc_pc, load_ac, load_pc, halt, err
//              data-path / memory controls, decoded from the registered state
//   state_o    current state encoding
//   instr_cnt  retired-instruction count, wraps modulo 2**IC_W
module seq_ctrl_ws #(
    parameter int unsigned TIMEOUT = 8,   // no-ack cycles before bus error, 0 = off
    parameter int unsigned TO_W    = 4,   // wait counter width, TIMEOUT < 2**TO_W
    parameter int unsigned IC_W    = 16   // retired-instruction counter width
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      opcode,
    input  logic            zero,
    input  logic            mem_ack,
    input  logic            resume,
    input  logic            step_en,
    input  logic            step,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            load_ir,
    output logic            inc_pc,
    output logic            load_ac,
    output logic            load_pc,
    output logic            halt,
    output logic            err,
    output logic [3:0]      state_o,
    output logic [IC_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_ADDR    = 4'd0,
        S_IFETCH  = 4'd1,
        S_ILOAD   = 4'd2,
        S_DECODE  = 4'd3,
        S_OPFETCH = 4'd4,
        S_EXEC    = 4'd5,
        S_STORE   = 4'd6,
        S_HALT    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam bit TO_EN = (TIMEOUT != 0);
    // Counter value on the last tolerated no-ack cycle; unused when TO_EN=0.
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t          state_q,  state_d;
    logic [2:0]      opcode_q, opcode_d;
    logic [TO_W-1:0] wcnt_q,   wcnt_d;
    logic [IC_W-1:0] icnt_q,   icnt_d;

    logic            is_alu;
    logic            wait_state;
    logic            to_hit;

    // ALU class is ADD, AND, XOR, LDA (010..101)
    assign is_alu     = (opcode_q >= 3'b010) && (opcode_q <= 3'b101);
    assign wait_state = (state_q == S_IFETCH) || (state_q == S_OPFETCH) ||
                        (state_q == S_STORE);
    // Only meaningful when no ack arrives this cycle; an ack always wins.
    assign to_hit     = TO_EN && (wcnt_q == TO_LAST);

    // Next-state, opcode capture, wait counter and retire counter
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wcnt_d   = '0;          // cleared whenever not in a wait state
        icnt_d   = icnt_q;

        if (wait_state && !mem_ack) begin
            if (to_hit) state_d = S_ERR;
            else        wcnt_d  = wcnt_q + TO_W'(1);
        end

        case (state_q)
            S_ADDR: begin
                if (!(step_en && !step)) state_d = S_IFETCH;
            end
            S_IFETCH: begin
                if (mem_ack) state_d = S_ILOAD;
            end
            S_ILOAD: begin
                opcode_d = opcode;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (opcode_q == OP_HLT) begin
                    state_d = S_HALT;
                    icnt_d  = icnt_q + IC_W'(1);
                end else if (opcode_q == OP_STO) begin
                    state_d = S_STORE;
                end else if (opcode_q == OP_SKZ || opcode_q == OP_JMP) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_OPFETCH;
                end
            end
            S_OPFETCH: begin
                if (mem_ack) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_ADDR;
                icnt_d  = icnt_q + IC_W'(1);
            end
            S_STORE: begin
                if (mem_ack) begin
                    state_d = S_ADDR;
                    icnt_d  = icnt_q + IC_W'(1);
                end
            end
            S_HALT: begin
                if (resume) state_d = S_ADDR;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    // State and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_ADDR;
            opcode_q <= '0;
            wcnt_q   <= '0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wcnt_q   <= wcnt_d;
            icnt_q   <= icnt_d;
        end
    end

    // Control decode; only state_q, opcode_q and zero feed it, so reset
    // clears every output as soon as state_q returns to ADDR.
    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        halt    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IFETCH:  mem_rd = 1'b1;
            S_ILOAD: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            S_DECODE:  inc_pc = 1'b1;
            S_OPFETCH: mem_rd = 1'b1;
            S_EXEC: begin
                if (is_alu) begin
                    mem_rd  = 1'b1;
                    load_ac = 1'b1;
                end else if (opcode_q == OP_SKZ) begin
                    inc_pc = zero;
                end else if (opcode_q == OP_JMP) begin
                    load_pc = 1'b1;
                end
            end
            S_STORE:   mem_wr = 1'b1;
            S_HALT:    halt   = 1'b1;
            S_ERR: begin
                err  = 1'b1;
                halt = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign instr_cnt = icnt_q;

endmodule

// File: tb/tb_seq_ctrl_ws.sv
// Testbench for seq_ctrl_ws: table of single instructions with expected
// latency and control signature, scoreboard queue, plus hand-written
// halt/resume, single-step, timeout, wrap and async-reset sequences.
module tb_seq_ctrl_ws;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_W    = 4;
    localparam int unsigned IC_W    = 2;

    logic            clk;
    logic            rst;
    logic [2:0]      opcode;
    logic            zero;
    logic            mem_ack;
    logic            resume;
    logic            step_en;
    logic            step;
    logic            mem_rd, mem_wr, load_ir, inc_pc, load_ac, load_pc, halt, err;
    logic [3:0]      state_o;
    logic [IC_W-1:0] instr_cnt;

    seq_ctrl_ws #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .IC_W(IC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .resume    (resume),
        .step_en   (step_en),
        .step      (step),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .inc_pc    (inc_pc),
        .load_ac   (load_ac),
        .load_pc   (load_pc),
        .halt      (halt),
        .err       (err),
        .state_o   (state_o),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       z;
        int         waits;    // no-ack cycles in OPFETCH/STORE before ack
        int         cycles;   // edges from ADDR to ADDR/HALT
        logic       ac;       // load_ac in EXEC
        logic       inc;      // inc_pc in EXEC
        logic       pc;       // load_pc in EXEC
        int         wr;       // mem_wr cycles
        int         end_st;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];
    int   n_chk;
    int   n_fail;
    int   exp_cnt;

    function automatic int outs();
        return int'({mem_rd, mem_wr, load_ir, inc_pc, load_ac, load_pc, halt, err});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from ADDR, measuring latency and control signature.
    task automatic run_instr(input vec_t v, input string tag);
        vec_t e;
        int   cyc = 0;
        int   wc  = 0;
        int   wr  = 0;
        logic ac = 1'b0, inc = 1'b0, pc = 1'b0, ovl = 1'b0, ac_out = 1'b0;
        bit   done = 1'b0;
        sb.push_back(v);
        opcode = v.op;
        zero   = v.z;
        while (!done && cyc < 40) begin
            if (state_o == 4'd4 || state_o == 4'd6) begin
                mem_ack = (wc >= v.waits);
                wc++;
            end else begin
                mem_ack = 1'b1;   // must be ignored outside wait states
            end
            #1;
            if (mem_rd && mem_wr) ovl = 1'b1;
            if (load_ac && state_o != 4'd5) ac_out = 1'b1;
            if (state_o == 4'd5) begin
                ac  = load_ac;
                inc = inc_pc;
                pc  = load_pc;
            end
            if (state_o == 4'd6 && mem_wr) wr++;
            tick();
            cyc++;
            step = 1'b0;
            if (state_o == 4'd0 || state_o == 4'd7 || state_o == 4'd8) done = 1'b1;
        end
        mem_ack = 1'b0;
        e = sb.pop_front();
        exp_cnt++;
        chk($sformatf("%s cycles", tag), cyc, e.cycles);
        chk($sformatf("%s end_state", tag), int'(state_o), e.end_st);
        chk($sformatf("%s exec_load_ac", tag), int'(ac), int'(e.ac));
        chk($sformatf("%s exec_inc_pc", tag), int'(inc), int'(e.inc));
        chk($sformatf("%s exec_load_pc", tag), int'(pc), int'(e.pc));
        chk($sformatf("%s mem_wr_cycles", tag), wr, e.wr);
        chk($sformatf("%s rd_wr_overlap", tag), int'(ovl), 0);
        chk($sformatf("%s load_ac_outside_exec", tag), int'(ac_out), 0);
        chk($sformatf("%s instr_cnt", tag), int'(instr_cnt), exp_cnt % (1 << IC_W));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_if;
        n_chk   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        rst     = 1'b0;
        opcode  = 3'b000;
        zero    = 1'b0;
        mem_ack = 1'b0;
        resume  = 1'b0;
        step_en = 1'b0;
        step    = 1'b0;

        //          op      z     w  cyc ac    inc   pc    wr end
        vecs[0]  = '{3'b010, 1'b0, 0, 6,  1'b1, 1'b0, 1'b0, 0, 0}; // ADD
        vecs[1]  = '{3'b001, 1'b1, 0, 5,  1'b0, 1'b1, 1'b0, 0, 0}; // SKZ z=1
        vecs[2]  = '{3'b001, 1'b0, 0, 5,  1'b0, 1'b0, 1'b0, 0, 0}; // SKZ z=0
        vecs[3]  = '{3'b110, 1'b0, 3, 8,  1'b0, 1'b0, 1'b0, 4, 0}; // STO +3
        vecs[4]  = '{3'b011, 1'b1, 2, 8,  1'b1, 1'b0, 1'b0, 0, 0}; // AND +2
        vecs[5]  = '{3'b100, 1'b0, 0, 6,  1'b1, 1'b0, 1'b0, 0, 0}; // XOR
        vecs[6]  = '{3'b101, 1'b0, 7, 13, 1'b1, 1'b0, 1'b0, 0, 0}; // LDA ack on 8th
        vecs[7]  = '{3'b110, 1'b1, 7, 12, 1'b0, 1'b0, 1'b0, 8, 0}; // STO ack on 8th
        vecs[8]  = '{3'b111, 1'b1, 0, 5,  1'b0, 1'b0, 1'b1, 0, 0}; // JMP
        vecs[9]  = '{3'b010, 1'b1, 1, 7,  1'b1, 1'b0, 1'b0, 0, 0}; // ADD +1
        vecs[10] = '{3'b000, 1'b0, 0, 4,  1'b0, 1'b0, 1'b0, 0, 7}; // HLT

        // Reset state
        #12;
        chk("reset state_o", int'(state_o), 0);
        chk("reset outputs", outs(), 0);
        chk("reset instr_cnt", int'(instr_cnt), 0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

        // HALT holds until resume
        repeat (3) tick();
        chk("halt hold state", int'(state_o), 7);
        chk("halt hold outputs", outs(), 8'h02);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume to ADDR", int'(state_o), 0);

        // Single-step: hold in ADDR, one instruction per pulse
        step_en = 1'b1;
        opcode  = 3'b111;
        repeat (3) tick();
        chk("step hold state", int'(state_o), 0);
        chk("step hold outputs", outs(), 0);
        step = 1'b1;
        run_instr(vecs[8], "step_jmp");
        repeat (2) tick();
        chk("step hold after jmp", int'(state_o), 0);
        step = 1'b1;
        run_instr(vecs[10], "step_hlt");
        resume = 1'b1;
        step   = 1'b1;
        tick();
        resume = 1'b0;
        step   = 1'b0;
        chk("resume+step to ADDR", int'(state_o), 0);
        tick();
        chk("step hold after resume", int'(state_o), 0);
        step_en = 1'b0;

        // Timeout in IFETCH
        opcode  = 3'b010;
        mem_ack = 1'b0;
        tick();
        n_if = 0;
        while (state_o == 4'd1 && n_if < 20) begin
            n_if++;
            tick();
        end
        chk("timeout ifetch cycles", n_if, 8);
        chk("timeout state", int'(state_o), 8);
        chk("timeout outputs", outs(), 8'h03);
        resume = 1'b1;
        repeat (3) tick();
        chk("err ignores resume", int'(state_o), 8);
        resume = 1'b0;

        // Reset out of ERR
        #2 rst = 1'b0;
        #1;
        chk("err reset state_o", int'(state_o), 0);
        chk("err reset outputs", outs(), 0);
        chk("err reset instr_cnt", int'(instr_cnt), 0);
        exp_cnt = 0;
        tick();
        rst = 1'b1;

        // Counter wrap with IC_W=2
        for (int i = 0; i < 5; i++) run_instr(vecs[8], $sformatf("wrap_jmp%0d", i));
        chk("wrap instr_cnt", int'(instr_cnt), 1);

        // Async reset in the middle of OPFETCH
        opcode  = 3'b010;
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;
        tick();
        chk("opfetch state", int'(state_o), 4);
        chk("opfetch outputs", outs(), 8'h80);
        #2 rst = 1'b0;
        #1;
        chk("opfetch reset state_o", int'(state_o), 0);
        chk("opfetch reset outputs", outs(), 0);
        chk("opfetch reset instr_cnt", int'(instr_cnt), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("first edge after reset", int'(state_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
